// File: rtl/seg7_scan_if.sv
// Frame-write handshake between system logic (master) and the 7-segment scan controller (slave).
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    wr_valid;
    logic [4*NUM_DIGITS-1:0] wr_data;
    logic                    wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed BCD scan controller with double-buffered frame and inter-digit dead time.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN suppresses enables of leading-zero digits.
module seg7_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 50000,
    parameter int DEAD_CYCLES  = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_en,
    seg7_scan_if.slave            wr,
    output logic [3:0]            bcd_out,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_done
);
    localparam int CNT_MAX = (DIGIT_CYCLES > DEAD_CYCLES) ? DIGIT_CYCLES : DEAD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int IW      = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] DIG_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHOW, DEAD} state_t;

    state_t                      state_q;
    logic [CW-1:0]               cnt_q;
    logic [IW-1:0]               idx_q;
    logic [NUM_DIGITS-1:0][3:0]  active_q;
    logic [NUM_DIGITS-1:0][3:0]  shadow_q;
    logic                        pending_q;
    logic [3:0]                  bcd_q;
    logic [NUM_DIGITS-1:0]       en_q;
    logic                        done_q;

    logic                        accept;
    logic                        blank;
    logic [NUM_DIGITS-1:0]       onehot;

    assign accept = wr.wr_valid & ~pending_q;
    assign onehot = NUM_DIGITS'(1) << idx_q;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Current digit and everything above it are zero; digit 0 is never blanked.
    assign blank = (idx_q != '0) && ((active_q >> {idx_q, 2'b00}) == '0);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            bcd_q     <= 4'h0;
            en_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    en_q <= '0;
                    if (pending_q) begin
                        active_q  <= shadow_q;
                        pending_q <= 1'b0;
                    end
                    if (scan_en) begin
                        state_q <= SHOW;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                SHOW: begin
                    en_q  <= blank ? '0 : onehot;
                    bcd_q <= active_q[idx_q];
                    if (cnt_q == DIG_LAST) begin
                        state_q <= DEAD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DEAD: begin
                    en_q <= '0;
                    if (cnt_q == DEAD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= scan_en ? SHOW : IDLE;
                        if (idx_q == IDX_LAST) begin
                            // Frame boundary: swap in any pending frame so no frame tears.
                            done_q <= 1'b1;
                            idx_q  <= '0;
                            if (pending_q) begin
                                active_q  <= shadow_q;
                                pending_q <= 1'b0;
                            end
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Only accepted while nothing is pending, so never collides with a swap above.
            if (accept) begin
                shadow_q  <= wr.wr_data;
                pending_q <= 1'b1;
            end
        end
    end

    assign wr.wr_ready = ~pending_q;
    assign bcd_out     = bcd_q;
    assign digit_en    = en_q;
    assign frame_done  = done_q;
endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Time-multiplexed scan controller that drives one shared BCD-to-7-segment decoder across NUM_DIGITS common-cathode digits.
- Holds a frame buffer of BCD digits and presents one digit at a time on bcd_out, with the matching one-hot digit enable.
- Inserts a dead-time gap between digits to prevent ghosting.
- Sits between system logic (which writes digit values) and the combinational decoder feeding the segment pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 2..8.
- DIGIT_CYCLES, 50000: clock cycles each digit is enabled; must be >= 2.
- DEAD_CYCLES, 500: clock cycles with all enables low between digits; must be >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- scan_en  input  1  1 = scanning runs; 0 = finish current slot, then idle blanked.
- wr_valid  input  1  frame write request.
- wr_data  input  4*NUM_DIGITS  new frame; digit i at bits [4i+3:4i]; digit 0 = rightmost.
- wr_ready  output  1  1 when no frame is pending; write accepted when wr_valid && wr_ready.
- bcd_out  output  4  BCD code to decoder for the active digit.
- digit_en  output  NUM_DIGITS  one-hot active-high digit enable; all-zero during dead time and idle.
- frame_done  output  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset (rst_n low, async): state=IDLE, digit index=0, counter=0, frame buffer=0, pending=0. Outputs: bcd_out=4'h0, digit_en=0, wr_ready=1, frame_done=0.
- Buffering:
  - Accepted write goes to a shadow register and sets pending; wr_ready drops the next cycle.
  - The active frame updates from shadow only at a frame boundary (the cycle frame_done pulses) or while IDLE; pending then clears. No tearing within a frame.
  - A write accepted in the same cycle as a boundary is held for the next boundary.
- States:
  - IDLE: digit_en=0.
    - If scan_en=1: load pending shadow if any, set index=0, go to SHOW, counter=0.
  - SHOW: digit_en = one-hot(index); bcd_out = active digit[index]. Counter counts 0..DIGIT_CYCLES-1. On terminal count, go to DEAD, counter=0.
  - DEAD: digit_en=0; bcd_out holds. Counter counts 0..DEAD_CYCLES-1. On terminal count:
    - If index=NUM_DIGITS-1: pulse frame_done, wrap index to 0, apply shadow, go to SHOW if scan_en else IDLE.
    - Else: index+1, go to SHOW if scan_en else IDLE.
- Timing:
  - Outputs are registered; digit_en rises 1 cycle after entering SHOW.
  - Full frame period = NUM_DIGITS*(DIGIT_CYCLES+DEAD_CYCLES).
- Boundary rules:
  - scan_en drop mid-SHOW does not truncate the slot.
  - Restart from IDLE always begins at digit 0.
  - Invalid BCD (A..F) is passed through unchanged; the decoder blanks it.
  - Counter width = $clog2(max(DIGIT_CYCLES,DEAD_CYCLES)).

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: a digit whose value is 0 and all of whose higher-index digits are 0 keeps digit_en low during its SHOW slot. Slot timing is unchanged. Digit 0 is always displayed, so all-zero shows "0".
- Undefined: every digit is enabled during its slot.

Test Plan:
- Params NUM_DIGITS=4, DIGIT_CYCLES=4, DEAD_CYCLES=2.
- Reset then write 16'h1234, scan_en=1 -> digit_en sequence 0001,0000,0010,0000,0100,0000,1000,0000 with bcd_out 4,3,2,1; each enable 4 cycles; frame_done pulses every 24 cycles.
- Write 16'h5678 mid-frame -> wr_ready low until boundary; 1234 digits finish the frame; next frame shows 8,7,6,5; wr_ready returns to 1.
- scan_en dropped during digit 2 SHOW -> slot completes, dead time completes, digit_en stays 0; re-enable -> restart at digit 0.
- rst_n asserted mid-SHOW -> digit_en=0 and bcd_out=0 immediately (async), wr_ready=1, buffer cleared.
- Macro defined, write 16'h0070 -> digits 3 and 2 enables stay 0; digits 1 and 0 show 7 and 0. Write 16'h0000 -> only digit 0 enabled.
